// File: rtl/vnu_serial.sv
// vnu_serial: serial Variable Node Unit for a min-sum LDPC decoder.
//
// Flow:
//   - The channel LLR is latched on start.
//   - DV check-to-variable messages (CW-bit sign-magnitude) are accepted
//     one per handshake and summed with the LLR.
//   - DV extrinsic variable-to-check messages (VW-bit sign-magnitude) are
//     emitted one per handshake, together with a registered hard decision.
//
// Optional feature: define VNU_SCALE_EN to apply a floor-based 0.75
// normalisation to each extrinsic magnitude before saturation.
module vnu_serial #(
  parameter int DV = 3,
  parameter int CW = 5,
  parameter int VW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [VW-1:0] llr,
  input  logic          c_valid,
  output logic          c_ready,
  input  logic [CW-1:0] c_msg,
  output logic          v_valid,
  input  logic          v_ready,
  output logic [VW-1:0] v_msg,
  output logic          hard_bit,
  output logic          done
);

  // Index width: DV is at least 2, so $clog2(DV) is always at least 1.
  localparam int IW = $clog2(DV);

  // Accumulator width. VW+$clog2(DV)+2 bits holds the LLR plus DV check
  // magnitudes with headroom, so the sum can never overflow.
  localparam int AW = VW + $clog2(DV) + 2;

  // Magnitude width of an outgoing variable message.
  localparam int MW = VW - 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(DV - 1);
  localparam logic [AW-1:0] MAG_MAX  = AW'((1 << MW) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [AW-1:0] acc;
  logic        [IW-1:0] idx;
  logic        [CW-1:0] msg_buf [DV];

  logic        [IW-1:0] sel_idx;
  logic signed [AW-1:0] ext;
  logic        [VW-1:0] next_vmsg;

  logic start_ok;
  logic c_fire;
  logic v_fire;
  logic at_last;

  // Convert a check message to two's complement. Both +0 and -0 become 0.
  function automatic logic signed [AW-1:0] c_to_tc(input logic [CW-1:0] m);
    logic signed [AW-1:0] mag;
    mag = AW'(m[CW-2:0]);
    return m[CW-1] ? -mag : mag;
  endfunction

  // Convert a channel LLR to two's complement. Both +0 and -0 become 0.
  function automatic logic signed [AW-1:0] llr_to_tc(input logic [VW-1:0] l);
    logic signed [AW-1:0] mag;
    mag = AW'(l[VW-2:0]);
    return l[VW-1] ? -mag : mag;
  endfunction

  // Turn an extrinsic sum into a VW-bit sign-magnitude message.
  // The magnitude is optionally scaled, then saturated. A zero magnitude
  // always gets a positive sign, so negative zero is never produced.
  function automatic logic [VW-1:0] to_vmsg(input logic signed [AW-1:0] e);
    logic [AW-1:0] m;
    logic [AW-1:0] ms;
    logic [MW-1:0] sat;
    m = e[AW-1] ? $unsigned(-e) : $unsigned(e);
`ifdef VNU_SCALE_EN
    ms = m - (m >> 2);
`else
    ms = m;
`endif
    sat = (ms > MAG_MAX) ? MAG_MAX[MW-1:0] : ms[MW-1:0];
    return {e[AW-1] && (ms != '0), sat};
  endfunction

  // A start is honoured only in IDLE, and not in the cycle done is high,
  // so a back-to-back start lands one cycle after done.
  assign start_ok = (state == IDLE) && start && !done;
  assign c_fire   = c_valid && c_ready;
  assign v_fire   = v_valid && v_ready;
  assign at_last  = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the handshake outputs.
  always_comb begin
    state_next = state;
    c_ready    = 1'b0;
    v_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        c_ready = 1'b1;
        if (c_valid && at_last) begin
          state_next = CALC;
        end
      end
      CALC: begin
        state_next = EMIT;
      end
      EMIT: begin
        v_valid = 1'b1;
        if (v_ready && at_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select the edge whose message is registered next. CALC prepares edge 0.
  // An EMIT handshake prepares the following edge, so v_msg is always
  // registered one step ahead and stays stable while the consumer stalls.
  always_comb begin
    sel_idx = '0;
    if ((state == EMIT) && !at_last) begin
      sel_idx = idx + 1'b1;
    end
    ext       = acc - c_to_tc(msg_buf[sel_idx]);
    next_vmsg = to_vmsg(ext);
  end

  // Datapath: accumulator, edge index, message buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      idx      <= '0;
      v_msg    <= '0;
      hard_bit <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < DV; i++) begin
        msg_buf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            acc <= llr_to_tc(llr);
            idx <= '0;
          end
        end
        ACCUM: begin
          if (c_fire) begin
            msg_buf[idx] <= c_msg;
            acc          <= acc + c_to_tc(c_msg);
            idx          <= at_last ? '0 : idx + 1'b1;
          end
        end
        CALC: begin
          hard_bit <= acc[AW-1];
          v_msg    <= next_vmsg;
        end
        EMIT: begin
          if (v_fire) begin
            if (at_last) begin
              idx  <= '0;
              done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              v_msg <= next_vmsg;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vnu_serial.sv
// tb_vnu_serial: directed self-checking bench for vnu_serial (DV=3, CW=5, VW=6).
// Expected messages are hand-computed; the VNU_SCALE_EN build uses the
// 0.75-normalised values.
module tb_vnu_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] llr;
  logic       c_valid;
  logic       c_ready;
  logic [4:0] c_msg;
  logic       v_valid;
  logic       v_ready;
  logic [5:0] v_msg;
  logic       hard_bit;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  vnu_serial #(.DV(3), .CW(5), .VW(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .llr      (llr),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .c_msg    (c_msg),
    .v_valid  (v_valid),
    .v_ready  (v_ready),
    .v_msg    (v_msg),
    .hard_bit (hard_bit),
    .done     (done)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck DUT still terminates the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // One full update.
  //   gap:         idle cycles inserted before each c message after the first.
  //   stall:       cycles v_ready is held low on the second output.
  //   start_at_done: also pulse start in the cycle done is high.
  task automatic applyStimulus(input string tag, input logic [5:0] l,
                               input logic [4:0] c0, input logic [4:0] c1,
                               input logic [4:0] c2,
                               input logic [5:0] e0, input logic [5:0] e1,
                               input logic [5:0] e2,
                               input logic ehb, input int gap, input int stall,
                               input logic start_at_done);
    logic [4:0] cm [3];
    logic [5:0] em [3];
    int budget;
    cm = '{c0, c1, c2};
    em = '{e0, e1, e2};
    start = 1'b1;
    llr   = l;
    @(negedge clk);
    start = 1'b0;
    llr   = 6'h3f;
    checkOutput({tag, " c_ready"}, c_ready, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          c_valid = 1'b0;
          start   = 1'b1;
          @(negedge clk);
          start   = 1'b0;
        end
      end
      c_valid = 1'b1;
      c_msg   = cm[k];
      @(negedge clk);
    end
    c_valid = 1'b0;
    c_msg   = 5'h1f;
    checkOutput({tag, " calc c_ready"}, c_ready, 0);
    for (int k = 0; k < 3; k++) begin
      budget = 0;
      while (!v_valid && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      checkOutput($sformatf("%s v_valid%0d", tag, k), v_valid, 1);
      checkOutput($sformatf("%s v_msg%0d", tag, k), v_msg, em[k]);
      if (k == 1) begin
        for (int s = 0; s < stall; s++) begin
          v_ready = 1'b0;
          @(negedge clk);
          checkOutput($sformatf("%s stall%0d v_msg", tag, s), v_msg, em[k]);
        end
      end
      v_ready = 1'b1;
      @(negedge clk);
      v_ready = 1'b0;
    end
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " v_valid after"}, v_valid, 0);
    checkOutput({tag, " hard_bit"}, hard_bit, ehb);
    if (start_at_done) begin
      start = 1'b1;
      llr   = 6'h01;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " done pulse"}, done, 0);
    if (start_at_done) begin
      checkOutput({tag, " start@done ignored"}, c_ready, 0);
    end
  endtask

  // Expected values; the scaled build divides magnitudes by 4/3 (floor based).
`ifdef VNU_SCALE_EN
  localparam logic [5:0] A0 = 6'b000011, A1 = 6'b000111, A2 = 6'b000101;
  localparam logic [5:0] B0 = 6'b011111;
  localparam logic [5:0] C0 = 6'b101110, C1 = 6'b110000, C2 = 6'b101111;
`else
  localparam logic [5:0] A0 = 6'b000100, A1 = 6'b001001, A2 = 6'b000110;
  localparam logic [5:0] B0 = 6'b011111;
  localparam logic [5:0] C0 = 6'b110010, C1 = 6'b110101, C2 = 6'b110011;
`endif

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    llr     = '0;
    c_valid = 1'b0;
    c_msg   = '0;
    v_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset c_ready", c_ready, 0);
    checkOutput("reset v_valid", v_valid, 0);
    checkOutput("reset v_msg", v_msg, 0);
    checkOutput("reset hard_bit", hard_bit, 0);
    checkOutput("reset done", done, 0);

    applyStimulus("basic", 6'b000101, 5'b00011, 5'b10010, 5'b00001,
                  A0, A1, A2, 1'b0, 0, 0, 1'b0);
    applyStimulus("sat", 6'b011111, 5'b01111, 5'b01111, 5'b01111,
                  B0, B0, B0, 1'b0, 0, 0, 1'b0);
    applyStimulus("neg", 6'b110100, 5'b10001, 5'b00010, 5'b00000,
                  C0, C1, C2, 1'b1, 0, 0, 1'b0);

    // Reset in the middle of ACCUM after two accepts.
    start = 1'b1;
    llr   = 6'b000101;
    @(negedge clk);
    start   = 1'b0;
    c_valid = 1'b1;
    c_msg   = 5'b00011;
    @(negedge clk);
    c_msg   = 5'b10010;
    @(negedge clk);
    c_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset c_ready", c_ready, 0);
    checkOutput("midreset v_valid", v_valid, 0);
    checkOutput("midreset v_msg", v_msg, 0);
    checkOutput("midreset hard_bit", hard_bit, 0);
    checkOutput("midreset done", done, 0);

    applyStimulus("fresh", 6'b000101, 5'b00011, 5'b10010, 5'b00001,
                  A0, A1, A2, 1'b0, 0, 0, 1'b0);
    applyStimulus("negzero", 6'b100000, 5'b10000, 5'b10000, 5'b10000,
                  6'b000000, 6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);
    applyStimulus("flow", 6'b000101, 5'b00011, 5'b10010, 5'b00001,
                  A0, A1, A2, 1'b0, 2, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vnu_serial.md
Name: vnu_serial

Overview:
- Variable Node Unit for the min-sum LDPC decoder. It is the counterpart of the check node unit: it consumes check-to-variable messages in the 5-bit sign-magnitude format the CNU produces.
- It emits variable-to-check messages in the 6-bit sign-magnitude format the CNU consumes.
- One instance serves one variable node. The channel LLR is latched on start, DV check messages are accepted serially and accumulated, then DV extrinsic messages are emitted serially together with a hard-decision bit.

Parameters:
- DV, 3, variable-node degree (number of edges); legal range 2..8.
- CW, 5, check message width: sign bit plus CW-1 magnitude bits.
- VW, 6, variable message and LLR width: sign bit plus VW-1 magnitude bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; begins an update; honoured only in IDLE.
- llr  in  VW  channel LLR in sign-magnitude; sampled on an accepted start.
- c_valid  in  1  check message valid.
- c_ready  out  1  high in ACCUM.
- c_msg  in  CW  check message in sign-magnitude (MSB = 1 means negative).
- v_valid  out  1  variable message valid.
- v_ready  in  1  downstream accept.
- v_msg  out  VW  extrinsic message in sign-magnitude.
- hard_bit  out  1  hard decision; 1 means total < 0.
- done  out  1  one-cycle pulse after the last v handshake.

Behaviour:
- Reset. Applies on any clk edge with rst=1, including mid-operation. State goes to IDLE; accumulator, index and message buffer clear to 0. Outputs: c_ready=0, v_valid=0, v_msg=0, hard_bit=0, done=0. Partial work is discarded.
- Conversion. Sign-magnitude is converted to two's complement with sign extension. Both +0 and -0 (e.g. 10000) map to 0. The accumulator is signed, VW+$clog2(DV)+2 bits wide, and never overflows.
- IDLE. start=1 latches llr into acc, sets idx=0 and moves to ACCUM. start outside IDLE is ignored.
- ACCUM. c_ready=1. On each c_valid&c_ready edge: buf[idx]=c_msg, acc+=value(c_msg), idx++. On the DV-th accept, go to CALC and set idx=0. Cycles with c_valid=0 stall without state change.
- CALC. One cycle. c_ready=0. hard_bit is registered as acc<0; total 0 gives hard_bit=0. Then go to EMIT.
- EMIT. v_valid=1.
  - e = acc - value(buf[idx]). Output sign = (e<0). Magnitude = min(|e|, 2^(VW-1)-1), so it saturates at 31.
  - e=0 is output as all zeros. Negative zero is never output.
  - v_msg is registered and stable while v_valid=1 and v_ready=0.
  - On each v_valid&v_ready edge, idx++. After the DV-th handshake go to IDLE, assert done for one cycle and drop v_valid.
- Timing.
  - Minimum cycles from the start edge to the first v_valid: DV+2, with c_valid held high.
  - hard_bit holds its value until the next CALC.
  - A start arriving in the same cycle as done is ignored; the unit re-arms in the next cycle.

Optional Feature:
- Macro VNU_SCALE_EN.
- When defined: each extrinsic magnitude is scaled before saturation as m' = m - (m>>2), i.e. floor-based 0.75 normalisation. Sign is unchanged; m'=0 forces sign 0. hard_bit is unaffected.
- When undefined: no scaling, exactly as above.

Test Plan:
- DV=3, llr=000101 (+5), c_msg 00011, 10010, 00001 (total +7) -> v_msg 000100, 001001, 000110; hard_bit=0; done pulses once after the third handshake.
- llr=011111, c_msg 01111 x3 (total +76) -> v_msg 011111 x3, saturated; hard_bit=0.
- llr=110100 (-20), c_msg 10001, 00010, 00000 (total -19) -> v_msg 110010, 110101, 110011; hard_bit=1.
- llr=100000, c_msg 10000 x3 (negative zeros) -> v_msg 000000 x3; hard_bit=0.
- Flow control: c_valid gapped 2 cycles between messages, and v_ready held low 3 cycles on the second output -> v_msg stable while stalled; results identical to the first case. Also pulse rst during ACCUM after 2 accepts -> IDLE, outputs zero; a fresh run of the first case passes.
- With VNU_SCALE_EN, the first case -> v_msg 000011, 000111, 000101; hard_bit=0.
